// File: rtl/max7219_chain_ctrl_pkg.sv
// Shared constants, state encodings and the hex-to-segment table for the
// MAX7219 daisy-chain controller.
package max7219_pkg;

    localparam logic [3:0] REG_DECODE    = 4'h9;
    localparam logic [3:0] REG_INTENSITY = 4'hA;
    localparam logic [3:0] REG_SCANLIMIT = 4'hB;
    localparam logic [3:0] REG_SHUTDOWN  = 4'hC;
    localparam logic [3:0] REG_TEST      = 4'hF;

    typedef enum logic [2:0] {
        ST_POR_WAIT,
        ST_CFG,
        ST_FRAME_START,
        ST_SET_INT,
        ST_SET_BLANK,
        ST_ROW
    } ctrl_state_e;

    typedef enum logic [2:0] {
        SH_IDLE,
        SH_SETUP,
        SH_BITS,
        SH_TAIL,
        SH_HOLD
    } shift_state_e;

    function automatic logic [15:0] make_word(input logic [3:0] addr, input logic [7:0] data);
        return {4'h0, addr, data};
    endfunction

    // Segment bits are {DP,a,b,c,d,e,f,g}; DP is never lit.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0: seg = 8'h7E;
            4'h1: seg = 8'h30;
            4'h2: seg = 8'h6D;
            4'h3: seg = 8'h79;
            4'h4: seg = 8'h33;
            4'h5: seg = 8'h5B;
            4'h6: seg = 8'h5F;
            4'h7: seg = 8'h70;
            4'h8: seg = 8'h7F;
            4'h9: seg = 8'h7B;
            4'hA: seg = 8'h77;
            4'hB: seg = 8'h1F;
            4'hC: seg = 8'h4E;
            4'hD: seg = 8'h3D;
            4'hE: seg = 8'h4F;
            default: seg = 8'h47;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/max7219_chain_ctrl_if.sv
// User-side value bus and MAX7219 header pins, plus FSM state taps.
// master = controller view, slave = user/board view.
interface max7219_chain_ctrl_if
    import max7219_pkg::*;
#(
    parameter int N_DEV    = 1,
    parameter int N_DIGITS = 8
);
    logic [N_DEV*4*N_DIGITS-1:0] display_value;
    logic [3:0]                  intensity;
    logic                        blank;
    logic                        max_din;
    logic                        max_clk;
    logic                        max_load;
    logic                        init_done;
    logic                        frame_done;
    ctrl_state_e                 dbg_state;
    shift_state_e                dbg_shift_state;

    modport master (
        input  display_value, intensity, blank,
        output max_din, max_clk, max_load, init_done, frame_done,
        output dbg_state, dbg_shift_state
    );

    modport slave (
        output display_value, intensity, blank,
        input  max_din, max_clk, max_load, init_done, frame_done,
        input  dbg_state, dbg_shift_state
    );
endinterface

// File: rtl/max7219_chain_ctrl_shift.sv
// Write-only SPI shifter: one start pulse sends a W-bit vector MSB first,
// then holds LOAD high for LOAD_HOLD cycles before accepting the next start.
module max7219_shift
    import max7219_pkg::*;
#(
    parameter int W         = 16,
    parameter int CLK_DIV   = 128,
    parameter int LOAD_HOLD = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic [W-1:0] i_data,
    output logic         o_busy,
    output logic         o_din,
    output logic         o_clk,
    output logic         o_load,
    output shift_state_e o_state
);
    localparam int HALF   = CLK_DIV / 2;
    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int BIT_W  = $clog2(W);
    localparam int HOLD_W = $clog2(LOAD_HOLD + 1);

    shift_state_e      r_state;
    logic [W-1:0]      r_sreg;
    logic [DIV_W-1:0]  r_div_cnt;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_din, r_clk, r_load, r_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= SH_IDLE;
            r_sreg     <= '0;
            r_div_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_hold_cnt <= '0;
            r_din      <= 1'b0;
            r_clk      <= 1'b0;
            r_load     <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                SH_IDLE: if (i_start) begin
                    r_sreg  <= i_data;
                    r_load  <= 1'b0;
                    r_busy  <= 1'b1;
                    r_state <= SH_SETUP;
                end
                SH_SETUP: begin
                    r_din     <= r_sreg[W-1];
                    r_sreg    <= r_sreg << 1;
                    r_div_cnt <= '0;
                    r_bit_cnt <= '0;
                    r_state   <= SH_BITS;
                end
                SH_BITS: begin
                    r_div_cnt <= r_div_cnt + DIV_W'(1);
                    if (r_div_cnt == DIV_W'(HALF - 1)) r_clk <= 1'b1;
                    // End of the high phase: next bit's data goes out with the falling edge.
                    if (r_div_cnt == DIV_W'(CLK_DIV - 1)) begin
                        r_clk     <= 1'b0;
                        r_div_cnt <= '0;
                        if (r_bit_cnt == BIT_W'(W - 1)) begin
                            r_state <= SH_TAIL;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                            r_din     <= r_sreg[W-1];
                            r_sreg    <= r_sreg << 1;
                        end
                    end
                end
                SH_TAIL: begin
                    r_load     <= 1'b1;
                    r_din      <= 1'b0;
                    r_hold_cnt <= '0;
                    r_state    <= SH_HOLD;
                end
                SH_HOLD: begin
                    r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                    if (r_hold_cnt == HOLD_W'(LOAD_HOLD - 1)) begin
                        r_busy  <= 1'b0;
                        r_state <= SH_IDLE;
                    end
                end
                default: r_state <= SH_IDLE;
            endcase
        end
    end

    assign o_busy  = r_busy;
    assign o_din   = r_din;
    assign o_clk   = r_clk;
    assign o_load  = r_load;
    assign o_state = r_state;
endmodule

// File: rtl/max7219_chain_ctrl.sv
// Daisy-chain MAX7219 controller: power-on wait, configuration, then
// continuous frame refresh with frame-coherent snapshots of the user inputs.
module max7219_chain_ctrl
    import max7219_pkg::*;
#(
    parameter int N_DEV      = 1,
    parameter int N_DIGITS   = 8,
    parameter int CLK_DIV    = 128,
    parameter int POR_CYCLES = 1048576,
    parameter int LOAD_HOLD  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    max7219_chain_ctrl_if.master bus
);
    localparam int W     = N_DEV * 16;
    localparam int VW    = N_DEV * 4 * N_DIGITS;
    localparam int POR_W = $clog2(POR_CYCLES + 1);

    ctrl_state_e      r_state;
    logic [POR_W-1:0] r_por_cnt;
    logic [2:0]       r_idx;
    logic [3:0]       r_digit;
    logic             r_issued, r_start;
    logic [W-1:0]     r_word;
    logic [VW-1:0]    r_snap_val;
    logic [3:0]       r_snap_int, r_app_int;
    logic             r_snap_blank, r_app_blank;
    logic             r_init_done, r_frame_done;
    logic             w_busy;
    logic             w_txn_done;

    function automatic logic [W-1:0] bcast(input logic [3:0] addr, input logic [7:0] data);
        logic [W-1:0] w;
        for (int k = 0; k < N_DEV; k++) w[k*16 +: 16] = make_word(addr, data);
        return w;
    endfunction

    function automatic logic [W-1:0] row_word(input logic [VW-1:0] v, input logic [3:0] dig);
        logic [W-1:0] w;
        for (int k = 0; k < N_DEV; k++)
            w[k*16 +: 16] = make_word(dig, hex_to_seg(v[k*4*N_DIGITS + (int'(dig) - 1)*4 +: 4]));
        return w;
    endfunction

    function automatic logic [W-1:0] cfg_word(input logic [2:0] idx, input logic [3:0] inten,
                                              input logic blk);
        case (idx)
            3'd0:    return bcast(REG_SHUTDOWN, 8'h00);
            3'd1:    return bcast(REG_TEST, 8'h00);
            3'd2:    return bcast(REG_SCANLIMIT, 8'(N_DIGITS - 1));
            3'd3:    return bcast(REG_DECODE, 8'h00);
            3'd4:    return bcast(REG_INTENSITY, {4'h0, inten});
            default: return bcast(REG_SHUTDOWN, {7'h0, ~blk});
        endcase
    endfunction

    // r_start blocks the done test for the one cycle before the shifter raises busy.
    assign w_txn_done = r_issued && !r_start && !w_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_POR_WAIT;
            r_por_cnt    <= '0;
            r_idx        <= '0;
            r_digit      <= 4'd1;
            r_issued     <= 1'b0;
            r_start      <= 1'b0;
            r_word       <= '0;
            r_snap_val   <= '0;
            r_snap_int   <= '0;
            r_app_int    <= '0;
            r_snap_blank <= 1'b0;
            r_app_blank  <= 1'b0;
            r_init_done  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_start      <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                ST_POR_WAIT: begin
                    if (r_por_cnt == POR_W'(POR_CYCLES - 1)) r_state <= ST_CFG;
                    else r_por_cnt <= r_por_cnt + POR_W'(1);
                end
                ST_CFG: begin
                    if (!r_issued) begin
                        r_word   <= cfg_word(r_idx, bus.intensity, bus.blank);
                        r_start  <= 1'b1;
                        r_issued <= 1'b1;
                        if (r_idx == 3'd4) r_app_int <= bus.intensity;
                        if (r_idx == 3'd5) r_app_blank <= bus.blank;
                    end else if (w_txn_done) begin
                        r_issued <= 1'b0;
                        if (r_idx == 3'd5) begin
                            r_init_done <= 1'b1;
                            r_state     <= ST_FRAME_START;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end
                end
                ST_FRAME_START: begin
                    r_snap_val   <= bus.display_value;
                    r_snap_int   <= bus.intensity;
                    r_snap_blank <= bus.blank;
                    r_state      <= ST_SET_INT;
                end
                ST_SET_INT: begin
                    if (w_txn_done) begin
                        r_issued <= 1'b0;
                        r_state  <= ST_SET_BLANK;
                    end else if (!r_issued) begin
                        if (r_snap_int != r_app_int) begin
                            r_word    <= bcast(REG_INTENSITY, {4'h0, r_snap_int});
                            r_start   <= 1'b1;
                            r_issued  <= 1'b1;
                            r_app_int <= r_snap_int;
                        end else begin
                            r_state <= ST_SET_BLANK;
                        end
                    end
                end
                ST_SET_BLANK: begin
                    if (w_txn_done) begin
                        r_issued <= 1'b0;
                        r_digit  <= 4'd1;
                        r_state  <= ST_ROW;
                    end else if (!r_issued) begin
                        if (r_snap_blank != r_app_blank) begin
                            r_word      <= bcast(REG_SHUTDOWN, {7'h0, ~r_snap_blank});
                            r_start     <= 1'b1;
                            r_issued    <= 1'b1;
                            r_app_blank <= r_snap_blank;
                        end else begin
                            r_digit <= 4'd1;
                            r_state <= ST_ROW;
                        end
                    end
                end
                ST_ROW: begin
                    if (!r_issued) begin
                        r_word   <= row_word(r_snap_val, r_digit);
                        r_start  <= 1'b1;
                        r_issued <= 1'b1;
                    end else if (w_txn_done) begin
                        r_issued <= 1'b0;
                        if (r_digit == 4'(N_DIGITS)) begin
                            r_frame_done <= 1'b1;
                            r_state      <= ST_FRAME_START;
                        end else begin
                            r_digit <= r_digit + 4'd1;
                        end
                    end
                end
                default: r_state <= ST_POR_WAIT;
            endcase
        end
    end

    max7219_shift #(
        .W         (W),
        .CLK_DIV   (CLK_DIV),
        .LOAD_HOLD (LOAD_HOLD)
    ) u_shift (
        .clk     (clk),
        .rst     (rst),
        .i_start (r_start),
        .i_data  (r_word),
        .o_busy  (w_busy),
        .o_din   (bus.max_din),
        .o_clk   (bus.max_clk),
        .o_load  (bus.max_load),
        .o_state (bus.dbg_shift_state)
    );

    assign bus.init_done  = r_init_done;
    assign bus.frame_done = r_frame_done;
    assign bus.dbg_state  = r_state;
endmodule

// File: tb/tb_max7219_chain_ctrl.sv
// Directed bench for the MAX7219 chain controller: an SPI sink captures each
// 32-bit transaction and compares it against a queue of expected words.
module tb_max7219_chain_ctrl;
  localparam int N_DEV = 2;
  localparam int N_DIGITS = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  max7219_chain_ctrl_if #(.N_DEV(N_DEV), .N_DIGITS(N_DIGITS)) bus ();

  max7219_chain_ctrl #(
    .N_DEV(N_DEV), .N_DIGITS(N_DIGITS), .CLK_DIV(4), .POR_CYCLES(16), .LOAD_HOLD(4)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int n_caps = 0;
  int n_frames = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] seg(input logic [3:0] n);
    case (n)
      4'h0: return 8'h7E; 4'h1: return 8'h30; 4'h2: return 8'h6D; 4'h3: return 8'h79;
      4'h4: return 8'h33; 4'h5: return 8'h5B; 4'h6: return 8'h5F; 4'h7: return 8'h70;
      4'h8: return 8'h7F; 4'h9: return 8'h7B; 4'hA: return 8'h77; 4'hB: return 8'h1F;
      4'hC: return 8'h4E; 4'hD: return 8'h3D; 4'hE: return 8'h4F; default: return 8'h47;
    endcase
  endfunction

  function automatic logic [31:0] bc(input logic [3:0] a, input logic [7:0] d);
    return {4'h0, a, d, 4'h0, a, d};
  endfunction

  function automatic logic [31:0] row_exp(input logic [63:0] v, input int d);
    logic [3:0] a;
    a = 4'(d);
    return {4'h0, a, seg(v[32 + (d-1)*4 +: 4]), 4'h0, a, seg(v[(d-1)*4 +: 4])};
  endfunction

  task automatic push_cfg(input logic [3:0] inten, input logic blk);
    exp_q.push_back(bc(4'hC, 8'h00));
    exp_q.push_back(bc(4'hF, 8'h00));
    exp_q.push_back(bc(4'hB, 8'h07));
    exp_q.push_back(bc(4'h9, 8'h00));
    exp_q.push_back(bc(4'hA, {4'h0, inten}));
    exp_q.push_back(bc(4'hC, {7'h0, ~blk}));
  endtask

  task automatic push_frame(input logic [63:0] v);
    for (int d = 1; d <= N_DIGITS; d++) exp_q.push_back(row_exp(v, d));
  endtask

  task automatic wait_caps(input int target, input string tag);
    int t;
    t = 0;
    while (n_caps < target && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk(tag, 32'(n_caps >= target), 32'd1);
  endtask

  task automatic wait_frames(input int target, input string tag);
    int t;
    t = 0;
    while (n_frames < target && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk(tag, 32'(n_frames >= target), 32'd1);
  endtask

  task automatic check_por_quiet(input string tag);
    logic moved;
    moved = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (bus.max_load !== 1'b1 || bus.max_clk !== 1'b0) moved = 1'b1;
    end
    chk(tag, 32'(moved), 32'd0);
  endtask

  task automatic wait_init(input string tag);
    int t;
    t = 0;
    while (bus.init_done !== 1'b1 && t < 30) begin
      @(negedge clk);
      t++;
    end
    chk(tag, 32'(bus.init_done), 32'd1);
  endtask

  // SPI sink and timing monitor.
  logic [31:0] m_bits;
  int m_nbits, m_hi_len, m_since_fall, m_rows;
  logic m_din_moved, m_prev_clk, m_prev_din, m_prev_load, m_prev_fd;

  always @(negedge clk) begin
    if (rst) begin
      m_bits = '0; m_nbits = 0; m_hi_len = 0; m_since_fall = 0; m_rows = 0;
      m_din_moved = 1'b0;
    end else begin
      m_since_fall++;
      if (bus.max_clk && !m_prev_clk) begin
        m_bits = {m_bits[30:0], bus.max_din};
        m_nbits++;
        m_hi_len = 1;
        m_din_moved = 1'b0;
      end else if (bus.max_clk && m_prev_clk) begin
        m_hi_len++;
        if (bus.max_din !== m_prev_din) m_din_moved = 1'b1;
      end
      if (!bus.max_clk && m_prev_clk) begin
        chk("clk_high_len", 32'(m_hi_len), 32'd2);
        chk("din_stable_high", 32'(m_din_moved), 32'd0);
        m_since_fall = 0;
      end
      if (bus.max_load && !m_prev_load) begin
        chk("load_after_clk_fall", 32'(m_since_fall), 32'd1);
        chk("bit_count", 32'(m_nbits), 32'd32);
        chk("word_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("spi_word", m_bits, exp_q.pop_front());
        if (m_bits[27:24] >= 4'd1 && m_bits[27:24] <= 4'd8) m_rows++;
        m_nbits = 0;
        n_caps++;
      end
      if (bus.frame_done) begin
        chk("frame_rows", 32'(m_rows), 32'(N_DIGITS));
        chk("frame_pulse_width", 32'(m_prev_fd), 32'd0);
        m_rows = 0;
        n_frames++;
      end
    end
    m_prev_clk = bus.max_clk;
    m_prev_din = bus.max_din;
    m_prev_load = bus.max_load;
    m_prev_fd = bus.frame_done;
  end

  logic [63:0] v1, v2, v3;
  int base, t;

  initial begin
    v1 = 64'h01234567_89ABCDEF;
    v2 = 64'hFEDCBA98_76543210;
    v3 = {32'($urandom), 32'($urandom)};
    bus.display_value = v1;
    bus.intensity = 4'd7;
    bus.blank = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_din", 32'(bus.max_din), 32'd0);
    chk("rst_clk", 32'(bus.max_clk), 32'd0);
    chk("rst_load", 32'(bus.max_load), 32'd1);
    chk("rst_init_done", 32'(bus.init_done), 32'd0);
    chk("rst_frame_done", 32'(bus.frame_done), 32'd0);

    push_cfg(4'd7, 1'b0);
    push_frame(v1);
    @(posedge clk); #1 rst = 1'b0;
    check_por_quiet("por_quiet");

    wait_caps(5, "cfg_5_words");
    chk("init_done_before_last_cfg", 32'(bus.init_done), 32'd0);
    wait_caps(6, "cfg_6_words");
    wait_init("init_done_after_cfg");

    // Mid-frame changes must only show up in the next frame.
    wait_caps(9, "frame1_mid");
    bus.intensity = 4'd3;
    bus.display_value = v2;
    exp_q.push_back(bc(4'hA, 8'h03));
    push_frame(v2);
    wait_frames(1, "frame1_done");
    push_frame(v2);

    wait_caps(26, "frame3_mid");
    bus.blank = 1'b1;
    bus.intensity = 4'd9;
    bus.display_value = v3;
    exp_q.push_back(bc(4'hA, 8'h09));
    exp_q.push_back(bc(4'hC, 8'h00));
    push_frame(v3);

    wait_caps(35, "frame4_mid");
    bus.blank = 1'b0;
    exp_q.push_back(bc(4'hC, 8'h01));
    push_frame(v3);
    wait_caps(44, "frame5_mid");
    push_frame(v3);

    // Reset in the middle of a bit during a row transaction.
    wait_caps(52, "frame6_mid");
    chk("frames_before_reset", 32'(n_frames), 32'd5);
    t = 0;
    while (bus.max_clk !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("found_high_phase", 32'(bus.max_clk), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midbit_rst_load", 32'(bus.max_load), 32'd1);
    chk("midbit_rst_clk", 32'(bus.max_clk), 32'd0);
    chk("midbit_rst_init_done", 32'(bus.init_done), 32'd0);
    exp_q.delete();
    push_cfg(4'd9, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    base = n_caps;
    check_por_quiet("por_quiet_after_rst");
    wait_caps(base + 6, "cfg_again");
    wait_init("init_done_again");
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
